// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - round sequencing FSM for an iterative one-round-per-clock DES datapath
module des_round_ctrl #(
  parameter int          ROUNDS      = 16,
  parameter logic [15:0] SHIFT1_MASK = 16'h8103
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       decrypt,
  input  logic       abort,
  output logic       in_ready,
  output logic       ip_load,
  output logic       round_en,
  output logic [3:0] round_num,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       fp_load,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mode, mode_nxt;
  logic [3:0] dec_idx;

  // Decrypt walks the encrypt schedule backwards: round r (r>=1) reuses the
  // rotate amount of encrypt round ROUNDS-r. Written as LAST-cnt+1 so it stays
  // in 4 bits; the r=0 wrap value is never used because decrypt round 0 has no shift.
  assign dec_idx = LAST - cnt + 4'd1;

  // State, round counter and latched mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
    end
  end

  // Next-state logic plus output decode from registered state only
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    in_ready  = 1'b0;
    ip_load   = 1'b0;
    round_en  = 1'b0;
    round_num = 4'd0;
    key_shift = 2'd0;
    key_dir   = 1'b0;
    fp_load   = 1'b0;
    out_valid = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        cnt_nxt  = 4'd0;
        if (start && !abort) begin
          mode_nxt  = decrypt;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        ip_load   = 1'b1;
        cnt_nxt   = 4'd0;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        round_en  = 1'b1;
        round_num = cnt;
        key_dir   = mode;
        if (!mode) begin
          key_shift = SHIFT1_MASK[cnt] ? 2'd1 : 2'd2;
        end else if (cnt != 4'd0) begin
          key_shift = SHIFT1_MASK[dec_idx] ? 2'd1 : 2'd2;
        end
        if (cnt == LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = S_FINAL;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_FINAL: begin
        fp_load   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    // Abort wins over every other transition, including the HOLD handshake
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 4'd0;
    end
  end

endmodule
